// File: rtl/interval_timer.sv
// Programmable tick-based interval timer: prescaler plus down-counter, one-shot or periodic.
// Optional TIMER_PAUSE_EN adds a pause input that freezes the running interval.
module interval_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] period,
`ifdef TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             elapsed,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] period_q;
  logic             periodic_q;
  logic             hold;

`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign busy = (state == RUN);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the values from before the edge; reset is synchronous, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pre        <= '0;
      remaining  <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      elapsed    <= 1'b0;
    end else begin
      elapsed <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        pre       <= '0;
        remaining <= '0;
      end else if (start && period != '0) begin
        // Restart discards the current interval, including a coincident end strobe.
        state      <= RUN;
        pre        <= '0;
        remaining  <= period;
        period_q   <= period;
        periodic_q <= periodic;
      end else if (state == RUN && !hold) begin
        if (pre == PRE_LAST) begin
          pre <= '0;
          if (remaining == CNT_W'(1)) begin
            elapsed <= 1'b1;
            if (periodic_q) begin
              remaining <= period_q;
            end else begin
              remaining <= '0;
              state     <= IDLE;
            end
          end else begin
            remaining <= remaining - 1'b1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model (DIV=10 and DIV=1 instances).
module tb_interval_timer;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset, start, stop, periodic, pause;
  logic [7:0] period;
  logic       elapsed, busy;
  logic [7:0] remaining;

  logic       start1, stop1, periodic1, pause1;
  logic [7:0] period1;
  logic       elapsed1, busy1;
  logic [7:0] remaining1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: counts un-paused run cycles since the accepting edge.
  bit m_run, m_periodic, m_elapsed;
  int m_per, n;

  always #5 clk = ~clk;

  interval_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .periodic(periodic), .period(period),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .elapsed(elapsed), .busy(busy), .remaining(remaining)
  );

  interval_timer #(.CLK_HZ(1), .TICK_HZ(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1),
    .periodic(periodic1), .period(period1),
`ifdef TIMER_PAUSE_EN
    .pause(pause1),
`endif
    .elapsed(elapsed1), .busy(busy1), .remaining(remaining1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit hold_m;
`ifdef TIMER_PAUSE_EN
    hold_m = pause;
`else
    hold_m = 1'b0;
`endif
    m_elapsed = 1'b0;
    if (reset || stop) begin
      m_run = 1'b0;
      n     = 0;
    end else if (start && period != 0) begin
      m_run      = 1'b1;
      m_per      = period;
      m_periodic = periodic;
      n          = 0;
    end else if (m_run && !hold_m) begin
      n++;
      if (n % DIV == 0 && (n / DIV) % m_per == 0) begin
        m_elapsed = 1'b1;
        if (!m_periodic) m_run = 1'b0;
      end
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic step();
    int exp_rem;
    @(posedge clk);
    model_edge();
    #1;
    exp_rem = m_run ? m_per - (n / DIV) % m_per : 0;
    check("elapsed", elapsed, m_elapsed);
    check("busy", busy, m_run);
    check("remaining", remaining, exp_rem);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stop = 1'b0; periodic = 1'b1; period = 8'd5; pause = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; periodic1 = 1'b0; period1 = 8'd0; pause1 = 1'b0;
    m_run = 1'b0; m_periodic = 1'b0; m_elapsed = 1'b0; m_per = 1; n = 0;

    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0; start = 1'b0;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_remaining", remaining, 8'd0);

    // One-shot, period 3.
    start = 1'b1; period = 8'd3; periodic = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      step();
      if (i == 10) check("os_rem_10", remaining, 8'd2);
      if (i == 20) check("os_rem_20", remaining, 8'd1);
      if (i == 29) check("os_no_early", elapsed, 1'b0);
      if (i == 30) begin
        check("os_strobe", elapsed, 1'b1);
        check("os_busy_low", busy, 1'b0);
      end
      if (i == 31) check("os_width", elapsed, 1'b0);
    end

    // Periodic, period 2, stopped at E0+50.
    start = 1'b1; period = 8'd2; periodic = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 65; i++) begin
      stop = (i == 50);
      step();
      if (i == 20) check("per_strobe_20", elapsed, 1'b1);
      if (i == 40) check("per_strobe_40", elapsed, 1'b1);
      if (i == 40) check("per_reload", remaining, 8'd2);
      if (i == 50) check("per_stop_busy", busy, 1'b0);
      if (i == 60) check("per_no_strobe_60", elapsed, 1'b0);
    end
    stop = 1'b0;

    // Zero period is ignored.
    start = 1'b1; period = 8'd0; periodic = 1'b1;
    step();
    start = 1'b0;
    check("zero_busy", busy, 1'b0);
    for (int i = 0; i < 15; i++) step();

    // Stop coinciding with one-shot interval end.
    start = 1'b1; period = 8'd3; periodic = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      stop = (i == 30);
      step();
      if (i == 30) check("stop_at_end", elapsed, 1'b0);
    end
    stop = 1'b0;

    // Restart with period 5 coinciding with one-shot interval end.
    start = 1'b1; period = 8'd3; periodic = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i <= 82; i++) begin
      start = (i == 30);
      period = (i == 30) ? 8'd5 : 8'd3;
      step();
      if (i == 30) begin
        check("restart_no_strobe", elapsed, 1'b0);
        check("restart_rem", remaining, 8'd5);
      end
      if (i == 79) check("restart_no_early", elapsed, 1'b0);
      if (i == 80) check("restart_strobe", elapsed, 1'b1);
    end
    start = 1'b0;

    // DIV=1, periodic, period 1: strobe every cycle until stop.
    start1 = 1'b1; period1 = 8'd1; periodic1 = 1'b1;
    step();
    start1 = 1'b0;
    check("div1_e0", elapsed1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("div1_strobe", elapsed1, 1'b1);
      check("div1_busy", busy1, 1'b1);
      check("div1_rem", remaining1, 8'd1);
    end
    stop1 = 1'b1;
    step();
    stop1 = 1'b0;
    step();
    check("div1_stop_strobe", elapsed1, 1'b0);
    check("div1_stop_busy", busy1, 1'b0);

`ifdef TIMER_PAUSE_EN
    // One-shot period 2 with a 7-cycle pause starting at E0+5.
    start = 1'b1; period = 8'd2; periodic = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      pause = (i >= 5 && i <= 11);
      step();
      if (i == 8) check("pause_busy", busy, 1'b1);
      if (i == 20) check("pause_no_20", elapsed, 1'b0);
      if (i == 27) check("pause_strobe_27", elapsed, 1'b1);
    end
    pause = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      stop     = ($urandom_range(0, 149) == 0);
      start    = ($urandom_range(0, 39) == 0);
      period   = 8'($urandom_range(0, 6));
      periodic = 1'($urandom_range(0, 1));
`ifdef TIMER_PAUSE_EN
      if ($urandom_range(0, 29) == 0) pause = ~pause;
`endif
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

- Programmable tick-based interval timer.
- Generates the single-cycle `elapsed` strobe consumed by the LED/blink stage downstream. That stage toggles an output once per strobe.
- Replaces the fixed five-second delay with a run-time period, one-shot or periodic mode, and explicit start/stop control.
- Internally, a clock prescaler produces ticks at `TICK_HZ`, and a down-counter counts ticks.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz.
- `TICK_HZ`, 1000, tick rate in Hz. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 1. `DIV = 1` is legal.
- `CNT_W`, 16, width of period and remaining-count.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: sampled each edge; arms the timer with `period` and `periodic`.
- `stop` input 1: sampled each edge; aborts the run.
- `periodic` input 1: latched at start. 1 = auto-reload, 0 = one-shot.
- `period` input CNT_W: interval in ticks, latched at start.
- `pause` input 1: present only with `TIMER_PAUSE_EN` (see Configuration).
- `elapsed` output 1: registered strobe, high exactly one cycle per interval end.
- `busy` output 1: high in RUN.
- `remaining` output CNT_W: ticks left in the current interval; 0 in IDLE.

## Operation
- **States:** IDLE, RUN.
- **Registers:**
  - prescaler `pre`, counting 0..DIV-1;
  - `remaining`;
  - latched `period_q` and `periodic_q`.
- **Tick:** a tick occurs on an edge in RUN when `pre == DIV-1`. On that edge `pre` wraps to 0; otherwise `pre` increments.
- **IDLE → RUN:** on `start == 1 && stop == 0 && period != 0`.
  - Latch `period_q` and `periodic_q`.
  - Set `remaining = period`, `pre = 0`, `busy = 1`.
- **Zero period:** `start` with `period == 0` is ignored; the block stays in IDLE with no strobe.
- **Tick with `remaining > 1`:** decrement `remaining`.
- **Tick with `remaining == 1` (interval end):** `elapsed` goes high for the next cycle.
  - If `periodic_q` is set: `remaining = period_q`, stay in RUN.
  - Otherwise: `remaining = 0`, go to IDLE, `busy = 0`.
- **Restart:** `start` in RUN (with `stop == 0`, `period != 0`) reloads the latches, `remaining`, and `pre = 0`. No strobe is produced for the aborted interval, even if it coincides with interval end.
- **`start` in RUN with `period == 0`:** ignored; the current run continues.
- **Stop:** `stop` in RUN goes to IDLE with `remaining = 0`, `pre = 0`, and no strobe, even on an interval-end edge.
- **Priority:** `reset` > `stop` > `start` > tick.
- **Arithmetic:** `remaining` is unsigned, never underflows, and never wraps. `pre` needs `$clog2(DIV)` bits, minimum 1.

## Timing
- **Reset values:** `elapsed = 0`, `busy = 0`, `remaining = 0`, state IDLE, `pre = 0`, latches 0.
- **First strobe:** when `start` is accepted at edge E0, the first `elapsed` high is driven by edge E0 + period·DIV.
- **Periodic strobes:** subsequent strobes follow every period·DIV edges, with no jitter.
- **`busy` timing:** `busy` rises at E0. In one-shot mode it falls at the same edge that raises `elapsed`.
- **Strobe width:** `elapsed` is always exactly one cycle, even with `DIV = 1` and `period = 1` in periodic mode, where it is high continuously, one strobe per cycle.
- **Reset mid-run:** a reset asserted mid-run clears everything at the next edge; no strobe is produced.

## Configuration
- **Macro:** `TIMER_PAUSE_EN`.
- **Defined:**
  - A `pause` input port exists.
  - While `pause == 1` in RUN, `pre` and `remaining` hold, no tick occurs, `busy` stays 1, and `elapsed` cannot fire.
  - `stop` and `start` still act while paused.
  - Released pause resumes with the same `pre` value, so total latency = period·DIV + paused cycles.
- **Undefined:** the port is absent; the timer never freezes.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), CNT_W=8.

- **Reset:** hold `reset` 3 cycles with `start = 1` → `elapsed`, `busy`, `remaining` all 0 throughout and 1 cycle after release.
- **One-shot:** `start` pulse with period=3, periodic=0 at edge E0 → `remaining` 3→2→1 at E0+10/+20; `elapsed` high only after E0+30; `busy` 0 from E0+30.
- **Periodic then stop:** `start` with period=2, periodic=1 → strobes at E0+20, +40, +60; `stop` at E0+50 → no strobe at +60, `busy` 0, `remaining` 0.
- **Boundary cases:**
  - `start` with period=0 → stays IDLE, no strobe.
  - `stop` asserted on the E0+30 interval-end edge of a one-shot → no strobe.
  - `start` (period=5) on that same edge → no strobe; restarts, next strobe at that edge +50.
- **DIV=1 (CLK_HZ=TICK_HZ=1), periodic, period=1** → `elapsed` high every cycle from E0+1 until `stop`.
- **`TIMER_PAUSE_EN` defined:** one-shot period=2; `pause` high 7 cycles starting at E0+5 → single strobe at E0+27.
